// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending sources, software mask, and a
// prioritised vector register; drives the CPU's single interrupt line.
module irq_ctrl #(
  parameter int unsigned N_SRC     = 4,
  parameter logic [7:0]  BASE_ADDR = 8'hF0,
  parameter int unsigned HOLDOFF   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [7:0]       bus_addr,
  input  logic [7:0]       bus_wdata,
  input  logic             bus_rw,
  input  logic             bus_en,
  output logic [7:0]       bus_rdata,
  output logic             bus_hit,
  output logic             interrupt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] ack_clr;
  logic [2:0]       idx;
  logic             found;
  logic             vld;
  logic             sel_mask;
  logic             sel_pend;
  logic             sel_vec;
  logic             wr_mask;
  logic             wr_pend;
  logic             ack;
  logic             unused_wdata;

  assign sel_mask = (bus_addr == BASE_ADDR);
  assign sel_pend = (bus_addr == BASE_ADDR + 8'd1);
  assign sel_vec  = (bus_addr == BASE_ADDR + 8'd2);
  assign bus_hit  = sel_mask | sel_pend | sel_vec;

  assign wr_mask  = bus_en & bus_rw & sel_mask;
  assign wr_pend  = bus_en & bus_rw & sel_pend;

  assign rise = irq_src & ~src_q;
  assign act  = pend & mask;
  assign vld  = |act;

  // Only a VEC read that finds something pending counts as an acknowledge.
  assign ack  = bus_en & ~bus_rw & sel_vec & vld;

  assign unused_wdata = ^bus_wdata;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (act[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      ack_clr[i] = ack && (idx == 3'(i));
    end
  end

  assign clr = (wr_pend ? bus_wdata[N_SRC-1:0] : '0) | ack_clr;

  always_comb begin
    bus_rdata = '0;
    if (sel_mask) begin
      bus_rdata[N_SRC-1:0] = mask;
    end else if (sel_pend) begin
      bus_rdata[N_SRC-1:0] = pend;
    end else if (sel_vec && vld) begin
      bus_rdata = {1'b1, 4'b0000, idx};
    end
  end

  // A rising edge in the same cycle as a clear keeps the bit pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask  <= '0;
      pend  <= '0;
      src_q <= '0;
    end else begin
      src_q <= irq_src;
      pend  <= (pend & ~clr) | rise;
      if (wr_mask) begin
        mask <= bus_wdata[N_SRC-1:0];
      end
    end
  end

  // interrupt is the registered decode of the previous state, giving the
  // edge -> pend -> REQ -> interrupt three-cycle path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      interrupt <= 1'b0;
    end else begin
      interrupt <= (state == REQ);
      case (state)
        IDLE: begin
          if (vld) begin
            state <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            state <= HOLD;
            cnt   <= 4'(HOLDOFF - 1);
          end else if (!vld) begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            state <= vld ? REQ : IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected read data and
// interrupt levels; a negedge monitor pops and compares them.
module tb_irq_ctrl;

  localparam logic [7:0] BASE   = 8'hF0;
  localparam logic [7:0] A_MASK = BASE;
  localparam logic [7:0] A_PEND = BASE + 8'd1;
  localparam logic [7:0] A_VEC  = BASE + 8'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_src = '0;
  logic [7:0] bus_addr = '0;
  logic [7:0] bus_wdata = '0;
  logic       bus_rw = 1'b0;
  logic       bus_en = 1'b0;
  logic [7:0] bus_rdata;
  logic       bus_hit;
  logic       interrupt;

  irq_ctrl #(
    .N_SRC    (4),
    .BASE_ADDR(BASE),
    .HOLDOFF  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_src  (irq_src),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rw   (bus_rw),
    .bus_en   (bus_en),
    .bus_rdata(bus_rdata),
    .bus_hit  (bus_hit),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      tag;
    logic [7:0] data;
    logic       hit;
  } rd_t;

  typedef struct {
    string tag;
    int    at;
    logic  val;
  } irq_t;

  rd_t  rd_q[$];
  irq_t irq_q[$];
  rd_t  re;
  irq_t ie;
  int   vectors = 0;
  int   miscompares = 0;

  always @(negedge clk) begin
    if (bus_en && !bus_rw) begin
      vectors++;
      if (rd_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_read cyc=%0d addr=%h rdata=%h", cyc, bus_addr, bus_rdata);
      end else begin
        re = rd_q.pop_front();
        if (bus_rdata !== re.data || bus_hit !== re.hit) begin
          miscompares++;
          $display("FAIL %s cyc=%0d: rdata=%h hit=%b, expected rdata=%h hit=%b",
                   re.tag, cyc, bus_rdata, bus_hit, re.data, re.hit);
        end
      end
    end
    while (irq_q.size() > 0 && irq_q[0].at <= cyc) begin
      ie = irq_q.pop_front();
      vectors++;
      if (ie.at != cyc || interrupt !== ie.val) begin
        miscompares++;
        $display("FAIL %s cyc=%0d (due %0d): interrupt=%b, expected %b",
                 ie.tag, cyc, ie.at, interrupt, ie.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_irq(input int dly, input logic v, input string tag);
    irq_q.push_back('{tag, cyc + dly, v});
  endtask

  task automatic expect_low(input int from, input int to, input string tag);
    for (int i = from; i <= to; i++) expect_irq(i, 1'b0, tag);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input logic hit,
                    input string tag);
    bus_en   = 1'b1;
    bus_rw   = 1'b0;
    bus_addr = a;
    rd_q.push_back('{tag, exp, hit});
    tick();
    bus_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus_en    = 1'b1;
    bus_rw    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    tick();
    bus_en = 1'b0;
    bus_rw = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    run(2);
    reset = 1'b0;

    // Reset state, decode boundaries, ten quiet cycles
    expect_low(0, 10, "reset_irq");
    rd(A_MASK, 8'h00, 1'b1, "reset_mask");
    rd(A_PEND, 8'h00, 1'b1, "reset_pend");
    rd(A_VEC, 8'h00, 1'b1, "reset_vec");
    rd(BASE + 8'd3, 8'h00, 1'b0, "miss_above");
    rd(BASE - 8'd1, 8'h00, 1'b0, "miss_below");
    run(6);

    // Single source, acknowledge, holdoff, back to idle
    wr(A_MASK, 8'h0F);
    rd(A_MASK, 8'h0F, 1'b1, "mask_rb");
    irq_src = 4'b0100;
    expect_low(0, 2, "t2_latency");
    expect_irq(3, 1'b1, "t2_rise");
    tick();
    irq_src = '0;
    run(2);
    expect_irq(1, 1'b1, "t2_ack_cycle");
    expect_low(2, 8, "t2_holdoff");
    rd(A_VEC, 8'h82, 1'b1, "t2_vec");
    run(8);
    rd(A_PEND, 8'h00, 1'b1, "t2_pend_clr");

    // Two simultaneous sources served in priority order
    irq_src = 4'b1010;
    expect_low(0, 2, "t3_latency");
    expect_irq(3, 1'b1, "t3_rise");
    tick();
    irq_src = '0;
    run(2);
    expect_irq(1, 1'b1, "t3_ack1_cycle");
    expect_low(2, 3, "t3_holdoff");
    expect_irq(4, 1'b1, "t3_rerise");
    rd(A_VEC, 8'h81, 1'b1, "t3_vec1");
    run(3);
    expect_irq(1, 1'b1, "t3_ack2_cycle");
    expect_low(2, 6, "t3_idle");
    rd(A_VEC, 8'h83, 1'b1, "t3_vec3");
    run(6);
    rd(A_PEND, 8'h00, 1'b1, "t3_pend_clr");

    // Masked source stays pending; unmasking raises it
    wr(A_MASK, 8'h00);
    irq_src = 4'b0001;
    expect_low(0, 6, "t4_masked");
    tick();
    irq_src = '0;
    run(3);
    rd(A_PEND, 8'h01, 1'b1, "t4_pend");
    wr(A_MASK, 8'h01);
    expect_irq(1, 1'b0, "t4_unmask_lat");
    expect_irq(2, 1'b1, "t4_unmask_rise");
    run(2);
    expect_irq(1, 1'b1, "t4_ack_cycle");
    expect_low(2, 4, "t4_holdoff");
    rd(A_VEC, 8'h80, 1'b1, "t4_vec");
    run(4);

    // Set wins over a coincident write-1-to-clear
    wr(A_MASK, 8'h00);
    expect_low(0, 5, "t5_masked");
    irq_src = 4'b0100;
    tick();
    irq_src = '0;
    tick();
    irq_src = 4'b0100;
    wr(A_PEND, 8'h04);
    irq_src = '0;
    rd(A_PEND, 8'h04, 1'b1, "t5_set_wins");
    wr(A_PEND, 8'h04);
    rd(A_PEND, 8'h00, 1'b1, "t5_w1c");

    // Reset mid-HOLD with pend=03; source held high across reset release
    wr(A_MASK, 8'h0F);
    irq_src = 4'b0011;
    expect_low(0, 2, "t6_latency");
    expect_irq(3, 1'b1, "t6_rise");
    tick();
    irq_src = '0;
    run(2);
    expect_irq(1, 1'b1, "t6_ack_cycle");
    expect_irq(2, 1'b0, "t6_hold");
    rd(A_VEC, 8'h80, 1'b1, "t6_vec");
    irq_src = 4'b0001;
    tick();
    reset = 1'b1;
    expect_low(1, 7, "t6_after_reset");
    rd(A_PEND, 8'h03, 1'b1, "t6_pend_hold");
    rd(A_PEND, 8'h00, 1'b1, "t6_pend_reset");
    reset = 1'b0;
    rd(A_VEC, 8'h00, 1'b1, "t6_vec_reset");
    rd(A_MASK, 8'h00, 1'b1, "t6_mask_reset");
    rd(A_PEND, 8'h01, 1'b1, "t6_edge_at_release");
    irq_src = '0;
    run(3);

    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover_expectations: reads=%0d irq=%0d, expected 0 and 0",
               rd_q.size(), irq_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
